// File: rtl/vram_blit_engine.sv
// Avalon-MM block-move engine (FILL / ascending COPY) in front of the 600-word text VRAM.
// Optional completion interrupt: define VRAM_BLIT_IRQ_EN to add the IRQ port and the CTRL.IE bit.
module vram_blit_engine #(
  parameter int VRAM_WORDS = 600,
  parameter int AW         = 11
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          AVL_READ,
  input  logic          AVL_WRITE,
  input  logic          AVL_CS,
  input  logic [2:0]    AVL_ADDR,
  input  logic [31:0]   AVL_WRITEDATA,
  output logic [31:0]   AVL_READDATA,
`ifdef VRAM_BLIT_IRQ_EN
  output logic          IRQ,
`endif
  output logic [AW-1:0] M_ADDR,
  output logic          M_READ,
  output logic          M_WRITE,
  output logic [31:0]   M_WRITEDATA,
  output logic [3:0]    M_BYTE_EN,
  input  logic          M_WAITREQUEST,
  input  logic [31:0]   M_READDATA
);

  localparam int CW = AW + 1;
  localparam int SW = AW + 2;
  localparam logic [SW-1:0] LIMIT = SW'(VRAM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RLAT = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t         state_reg, state_next;
  logic [AW-1:0]  src_reg, dst_reg;
  logic [CW-1:0]  count_reg, idx_reg;
  logic [31:0]    fill_reg, data_reg, readdata_reg;
  logic           op_reg, done_reg, err_reg;

  logic           avl_wr, wr_ctrl, busy, start_go, start_bad, start_run, op_new;
  logic           wr_accept, last_word, ie_bit, m_req;
  logic [SW-1:0]  dst_end, src_end;
  logic [CW-1:0]  idx_plus1;
  logic [31:0]    rd_mux;

  assign avl_wr   = AVL_CS & AVL_WRITE;
  assign wr_ctrl  = avl_wr & (AVL_ADDR == 3'd0);
  assign op_new   = AVL_WRITEDATA[1];
  assign busy     = (state_reg == S_RD) | (state_reg == S_RLAT) | (state_reg == S_WR);
  assign start_go = wr_ctrl & AVL_WRITEDATA[0] & ~busy;

  // Bounds are checked 13 bits wide so an out-of-range request can never wrap into range
  assign dst_end   = {2'b00, dst_reg} + {1'b0, count_reg};
  assign src_end   = {2'b00, src_reg} + {1'b0, count_reg};
  assign start_bad = (dst_end > LIMIT) | (op_new & (src_end > LIMIT));
  assign start_run = start_go & ~start_bad & (count_reg != '0);

  assign idx_plus1 = idx_reg + 1'b1;
  assign last_word = (idx_plus1 == count_reg);
  assign wr_accept = (state_reg == S_WR) & ~M_WAITREQUEST;

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic; FIN accepts a new START just like IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_FIN: begin
        if (start_run) begin
          state_next = op_new ? S_RD : S_WR;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RD: begin
        if (!M_WAITREQUEST) begin
          state_next = S_RLAT;
        end
      end
      S_RLAT: begin
        state_next = S_WR;
      end
      S_WR: begin
        if (!M_WAITREQUEST) begin
          if (last_word) begin
            state_next = S_FIN;
          end else begin
            state_next = op_reg ? S_RD : S_WR;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM: master-port outputs, all derived from registered state so they hold under stall
  always_comb begin
    M_READ      = 1'b0;
    M_WRITE     = 1'b0;
    M_ADDR      = '0;
    M_WRITEDATA = '0;
    case (state_reg)
      S_RD: begin
        M_READ = 1'b1;
        M_ADDR = src_reg + idx_reg[AW-1:0];
      end
      S_WR: begin
        M_WRITE     = 1'b1;
        M_ADDR      = dst_reg + idx_reg[AW-1:0];
        M_WRITEDATA = op_reg ? data_reg : fill_reg;
      end
      default: begin
      end
    endcase
  end

  assign m_req = M_READ | M_WRITE;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_en
      assign M_BYTE_EN[gi] = m_req;
    end
  endgenerate

  // Datapath and control/status registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      src_reg   <= '0;
      dst_reg   <= '0;
      count_reg <= '0;
      fill_reg  <= '0;
      idx_reg   <= '0;
      data_reg  <= '0;
      op_reg    <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      if (avl_wr && !busy) begin
        case (AVL_ADDR)
          3'd1:    src_reg   <= AVL_WRITEDATA[AW-1:0];
          3'd2:    dst_reg   <= AVL_WRITEDATA[AW-1:0];
          3'd3:    count_reg <= AVL_WRITEDATA[CW-1:0];
          3'd4:    fill_reg  <= AVL_WRITEDATA;
          default: begin
          end
        endcase
      end

      if (wr_ctrl && !busy) begin
        op_reg <= op_new;
      end

      if (start_run) begin
        idx_reg <= '0;
      end else if (wr_accept) begin
        idx_reg <= idx_plus1;
      end

      if (state_reg == S_RLAT) begin
        data_reg <= M_READDATA;
      end

      // Set conditions are written after the clear so they win in the same cycle
      if (wr_ctrl) begin
        done_reg <= 1'b0;
        err_reg  <= 1'b0;
      end
      if (start_go && start_bad) begin
        done_reg <= 1'b1;
        err_reg  <= 1'b1;
      end else if (start_go && (count_reg == '0)) begin
        done_reg <= 1'b1;
      end else if ((state_reg == S_FIN) && !start_go) begin
        done_reg <= 1'b1;
      end
    end
  end

`ifdef VRAM_BLIT_IRQ_EN
  logic ie_reg, irq_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ie_reg  <= 1'b0;
      irq_reg <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ie_reg <= AVL_WRITEDATA[4];
      end
      irq_reg <= wr_ctrl ? 1'b0 : (done_reg & ie_reg);
    end
  end

  assign IRQ    = irq_reg;
  assign ie_bit = ie_reg;
`else
  assign ie_bit = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (AVL_ADDR)
      3'd0: begin
        rd_mux[0] = busy;
        rd_mux[1] = op_reg;
        rd_mux[2] = done_reg;
        rd_mux[3] = err_reg;
        rd_mux[4] = ie_bit;
      end
      3'd1:    rd_mux[AW-1:0] = src_reg;
      3'd2:    rd_mux[AW-1:0] = dst_reg;
      3'd3:    rd_mux[CW-1:0] = count_reg;
      3'd4:    rd_mux         = fill_reg;
      default: rd_mux         = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      readdata_reg <= '0;
    end else if (AVL_CS && AVL_READ) begin
      readdata_reg <= rd_mux;
    end
  end

  assign AVL_READDATA = readdata_reg;

endmodule

// File: tb/tb_vram_blit_engine.sv
// Scoreboard bench for vram_blit_engine: a VRAM slave model answers the master port,
// expected master writes and CSR reads are queued by the stimulus and checked by monitors.
`timescale 1ns/1ps
module tb_vram_blit_engine;

  localparam int VW = 600;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
  logic [2:0]  AVL_ADDR = '0;
  logic [31:0] AVL_WRITEDATA = '0;
  logic [31:0] AVL_READDATA;
  logic [10:0] M_ADDR;
  logic        M_READ, M_WRITE;
  logic [31:0] M_WRITEDATA;
  logic [3:0]  M_BYTE_EN;
  logic        M_WAITREQUEST = 1'b0;
  logic [31:0] M_READDATA = '0;
`ifdef VRAM_BLIT_IRQ_EN
  logic        IRQ;
`endif

  vram_blit_engine dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
`ifdef VRAM_BLIT_IRQ_EN
    .IRQ(IRQ),
`endif
    .M_ADDR(M_ADDR), .M_READ(M_READ), .M_WRITE(M_WRITE), .M_WRITEDATA(M_WRITEDATA),
    .M_BYTE_EN(M_BYTE_EN), .M_WAITREQUEST(M_WAITREQUEST), .M_READDATA(M_READDATA)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic [10:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  logic [2:0]  rd_addr_q[$];
  logic [31:0] mem [0:VW-1];

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   n_wr = 0, n_rd = 0, n_pulse = 0, rd_oob = 0;
  int   first_wr_cyc = 0, last_wr_cyc = 0;
  bit   first_pend = 1'b0, stall_en = 1'b0;
  logic rd_fire = 1'b0;
  bit   rd_pend = 1'b0, held_v = 1'b0;
  logic [31:0] rd_pend_data = '0;
  logic [44:0] held = '0;
  wr_t         exp_wr;
  logic [31:0] exp_rd;
  logic [2:0]  exp_ra;

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    rd_fire <= AVL_CS & AVL_READ;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // VRAM slave model and master/CSR monitors, evaluated mid-cycle
  always @(negedge CLK) begin
    M_READDATA    = rd_pend ? rd_pend_data : 32'hDEADBEEF;
    rd_pend       = 1'b0;
    M_WAITREQUEST = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    if (RESET) held_v = 1'b0;
    if (held_v) begin
      chk("stall_hold", {M_READ, M_WRITE, M_ADDR, M_WRITEDATA}, held);
      held_v = 1'b0;
    end
    chk("byte_en", M_BYTE_EN, (M_READ | M_WRITE) ? 4'hF : 4'h0);
    if (M_READ | M_WRITE) begin
      n_pulse++;
      chk("rd_wr_exclusive", M_READ & M_WRITE, 1'b0);
      if (M_WAITREQUEST) begin
        held_v = 1'b1;
        held   = {M_READ, M_WRITE, M_ADDR, M_WRITEDATA};
      end
    end
    if (M_READ && !M_WAITREQUEST) begin
      n_rd++;
      if (M_ADDR >= VW) rd_oob++;
      rd_pend      = 1'b1;
      rd_pend_data = (M_ADDR < VW) ? mem[M_ADDR] : 32'h0;
    end
    if (M_WRITE && !M_WAITREQUEST) begin
      n_wr++;
      last_wr_cyc = cyc;
      if (first_pend) begin
        first_wr_cyc = cyc;
        first_pend   = 1'b0;
      end
      if (wr_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %08h, required none", M_ADDR, M_WRITEDATA);
      end else begin
        exp_wr = wr_q.pop_front();
        chk("mwrite_addr", M_ADDR, exp_wr.a);
        chk("mwrite_data", M_WRITEDATA, exp_wr.d);
      end
      if (M_ADDR < VW) mem[M_ADDR] = M_WRITEDATA;
    end
    if (rd_fire) begin
      if (rd_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_csr_read: got %08h, required none", AVL_READDATA);
      end else begin
        exp_rd = rd_q.pop_front();
        exp_ra = rd_addr_q.pop_front();
        $display("[%0d] csr read  reg%0d = %08h (want %08h)", cyc, exp_ra, AVL_READDATA, exp_rd);
        chk("csr_read", AVL_READDATA, exp_rd);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic avl_wr(input logic [2:0] a, input logic [31:0] d);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
    $display("[%0d] csr write reg%0d = %08h", cyc, a, d);
    @(posedge CLK);
    #1;
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic avl_rd(input logic [2:0] a, input logic [31:0] exp);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    rd_q.push_back(exp);
    rd_addr_q.push_back(a);
    @(posedge CLK);
    #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.a = 11'(a);
    e.d = d;
    wr_q.push_back(e);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, p0, w0, r0, o0;
    for (int k = 0; k < VW; k++) mem[k] = 32'hFFFF0000;

    // Reset state and register file
    tick(3);
    chk("reset_m_write", M_WRITE, 1'b0);
    chk("reset_m_read", M_READ, 1'b0);
    chk("reset_readdata", AVL_READDATA, 32'h0);
    RESET = 1'b0;
    tick(1);
    avl_rd(3'd0, 32'h0);
    avl_rd(3'd1, 32'h0);
    avl_rd(3'd3, 32'h0);
    avl_rd(3'd4, 32'h0);
    avl_wr(3'd1, 32'hFFFFFFFF);
    avl_rd(3'd1, 32'h7FF);
    avl_wr(3'd3, 32'hFFFFFFFF);
    avl_rd(3'd3, 32'hFFF);
    avl_wr(3'd4, 32'hCAFEF00D);
    avl_rd(3'd4, 32'hCAFEF00D);
    avl_rd(3'd5, 32'h0);
    avl_rd(3'd7, 32'h0);
    avl_wr(3'd0, 32'h10);
`ifdef VRAM_BLIT_IRQ_EN
    avl_rd(3'd0, 32'h10);
`else
    avl_rd(3'd0, 32'h0);
`endif
    avl_wr(3'd0, 32'h0);

    // Clear screen: 600 consecutive writes, DONE exactly 602 cycles after START
    avl_wr(3'd2, 32'd0);
    avl_wr(3'd3, 32'd600);
    avl_wr(3'd4, 32'h20202020);
    for (int k = 0; k < VW; k++) push_wr(k, 32'h20202020);
    first_pend = 1'b1;
    w0 = n_wr;
    t = cyc;
    avl_wr(3'd0, 32'h1);
    avl_rd(3'd0, 32'h1);
    wait_until(t + 50);
    avl_wr(3'd4, 32'h0);
    wait_until(t + 601);
    avl_rd(3'd0, 32'h0);
    avl_rd(3'd0, 32'h4);
    avl_rd(3'd4, 32'h20202020);
    chk("fill_first_cycle", first_wr_cyc, t + 1);
    chk("fill_last_cycle", last_wr_cyc, t + 600);
    chk("fill_write_count", n_wr - w0, 600);

    // Scroll up by 20 words: COPY SRC=20 DST=0 COUNT=580, 3 cycles per word
    for (int k = 0; k < VW; k++) mem[k] = k;
    avl_wr(3'd1, 32'd20);
    avl_wr(3'd2, 32'd0);
    avl_wr(3'd3, 32'd580);
    for (int k = 0; k < 580; k++) push_wr(k, k + 20);
    o0 = rd_oob;
    r0 = n_rd;
    t = cyc;
    avl_wr(3'd0, 32'h3);
    wait_until(t + 1741);
    avl_rd(3'd0, 32'h2);
    avl_rd(3'd0, 32'h6);
    chk("copy_read_count", n_rd - r0, 580);
    chk("copy_oob_reads", rd_oob - o0, 0);
    for (int k = 580; k < VW; k++) chk("copy_tail_untouched", mem[k], k);

    // Range errors and zero count: no bus traffic
    p0 = n_pulse;
    avl_wr(3'd2, 32'd590);
    avl_wr(3'd3, 32'd11);
    avl_wr(3'd0, 32'h1);
    avl_rd(3'd0, 32'hC);
    avl_wr(3'd2, 32'd0);
    avl_wr(3'd1, 32'd590);
    avl_wr(3'd0, 32'h3);
    avl_rd(3'd0, 32'hE);
    avl_wr(3'd3, 32'd0);
    avl_wr(3'd0, 32'h1);
    avl_rd(3'd0, 32'h4);
    tick(3);
    chk("error_no_traffic", n_pulse - p0, 0);

    // Exact-fit boundary: DST+COUNT == 600 is legal
    avl_wr(3'd2, 32'd589);
    avl_wr(3'd3, 32'd11);
    avl_wr(3'd4, 32'h5A5A5A5A);
    for (int k = 0; k < 11; k++) push_wr(589 + k, 32'h5A5A5A5A);
    avl_wr(3'd0, 32'h1);
    tick(15);
    avl_rd(3'd0, 32'h4);

    // Random stalls during a short overlapping COPY (SRC >= DST)
    for (int k = 0; k < VW; k++) mem[k] = 32'hA5000000 | k;
    avl_wr(3'd1, 32'd8);
    avl_wr(3'd2, 32'd0);
    avl_wr(3'd3, 32'd8);
    for (int k = 0; k < 8; k++) push_wr(k, 32'hA5000000 | (k + 8));
    stall_en = 1'b1;
    avl_wr(3'd0, 32'h3);
    tick(200);
    stall_en = 1'b0;
    tick(2);
    avl_rd(3'd0, 32'h6);
    for (int k = 0; k < 16; k++) chk("stall_copy_mem", mem[k], 32'hA5000000 | ((k < 8) ? k + 8 : k));

    // Overlap with SRC < DST replicates the first word forward
    mem[40] = 32'hCAFE0001;
    avl_wr(3'd1, 32'd40);
    avl_wr(3'd2, 32'd41);
    avl_wr(3'd3, 32'd3);
    for (int k = 41; k < 44; k++) push_wr(k, 32'hCAFE0001);
    avl_wr(3'd0, 32'h3);
    tick(15);
    avl_rd(3'd0, 32'h6);

    // START while busy is ignored; reset abandons the FILL after word 99
    for (int k = 0; k < VW; k++) mem[k] = k;
    avl_wr(3'd2, 32'd0);
    avl_wr(3'd3, 32'd600);
    avl_wr(3'd4, 32'h11111111);
    for (int k = 0; k < 100; k++) push_wr(k, 32'h11111111);
    w0 = n_wr;
    t = cyc;
    avl_wr(3'd0, 32'h1);
    wait_until(t + 10);
    avl_wr(3'd0, 32'h3);
    avl_rd(3'd0, 32'h1);
    wait_until(t + 100);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    @(negedge CLK);
    chk("after_reset_m_write", M_WRITE, 1'b0);
    chk("after_reset_m_read", M_READ, 1'b0);
    @(posedge CLK);
    #1;
    avl_rd(3'd0, 32'h0);
    avl_rd(3'd3, 32'h0);
    avl_rd(3'd4, 32'h0);
    tick(5);
    chk("reset_write_count", n_wr - w0, 100);
    for (int k = 100; k < VW; k++) chk("reset_untouched", mem[k], k);

`ifdef VRAM_BLIT_IRQ_EN
    // Interrupt follows DONE by one cycle and clears on a CTRL write
    avl_wr(3'd3, 32'd4);
    avl_wr(3'd4, 32'h0BADF00D);
    for (int k = 0; k < 4; k++) push_wr(k, 32'h0BADF00D);
    t = cyc;
    avl_wr(3'd0, 32'h11);
    wait_until(t + 6);
    chk("irq_before", IRQ, 1'b0);
    avl_rd(3'd0, 32'h14);
    chk("irq_set", IRQ, 1'b1);
    avl_wr(3'd0, 32'h10);
    chk("irq_cleared", IRQ, 1'b0);
`endif

    tick(3);
    chk("write_queue_drained", wr_q.size(), 0);
    chk("read_queue_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
